// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: tracks in-flight register writers over DEPTH stages and
// produces per-port operand forward selects plus a RAW issue stall for decode.
module fwd_scoreboard #(
    parameter int RW     = 5,
    parameter int NPORTS = 2,
    parameter int DEPTH  = 3,
    parameter int SELW   = $clog2(DEPTH+1),
    parameter int CW     = 16
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   issue_valid,
    input  logic                   issue_regwr,
    input  logic [RW-1:0]          issue_rd,
    input  logic [SELW-1:0]        issue_lat,
    input  logic [NPORTS*RW-1:0]   rs_addr,
    input  logic                   freeze,
    input  logic                   flush,
    output logic [NPORTS*SELW-1:0] fwd_sel,
    output logic                   stall_out,
    output logic [SELW-1:0]        pending_cnt,
    output logic [CW-1:0]          stall_cycles
);
    logic [DEPTH-1:0]  r_valid;
    logic [RW-1:0]     r_rd  [DEPTH];
    logic [SELW-1:0]   r_lat [DEPTH];
    logic [CW-1:0]     r_stall_cycles;
    logic [NPORTS-1:0] w_hazard;
    logic [NPORTS-1:0] w_hit;
    logic [SELW-1:0]   w_lat;
    logic              w_v0;
    logic [DEPTH-1:0]  w_valid_nxt;

    // Youngest matching stage decides per port; older copies are shadowed.
    always_comb begin
        fwd_sel  = '0;
        w_hazard = '0;
        w_hit    = '0;
        for (int p = 0; p < NPORTS; p++) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (!w_hit[p] && r_valid[k] && rs_addr[p*RW +: RW] != '0 &&
                    r_rd[k] == rs_addr[p*RW +: RW]) begin
                    w_hit[p] = 1'b1;
                    if (SELW'(k) >= r_lat[k])
                        fwd_sel[p*SELW +: SELW] = SELW'(k + 1);
                    else
                        w_hazard[p] = 1'b1;
                end
            end
        end
    end

    assign stall_out    = issue_valid & (|w_hazard);
    assign pending_cnt  = SELW'($countones(r_valid));
    assign stall_cycles = r_stall_cycles;
    assign w_lat = (issue_lat == '0) ? SELW'(1) :
                   (issue_lat > SELW'(DEPTH)) ? SELW'(DEPTH) : issue_lat;
    assign w_v0  = issue_valid & issue_regwr & (issue_rd != '0) & ~flush & ~stall_out;

    // A flush also kills the entry leaving stage 0, so stage 1 lands invalid.
    always_comb begin
        w_valid_nxt    = {r_valid[DEPTH-2:0], w_v0};
        w_valid_nxt[1] = w_valid_nxt[1] & ~flush;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid        <= '0;
            r_stall_cycles <= '0;
        end else if (!freeze) begin
            r_valid <= w_valid_nxt;
            if (!flush && stall_out && r_stall_cycles != '1)
                r_stall_cycles <= r_stall_cycles + CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!freeze) begin
            r_rd[0]  <= issue_rd;
            r_lat[0] <= w_lat;
            for (int k = 1; k < DEPTH; k++) begin
                r_rd[k]  <= r_rd[k-1];
                r_lat[k] <= r_lat[k-1];
            end
        end
    end
endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb_fwd_scoreboard: directed and random stimulus against a queue-based
// reference model; expected outputs are queued and checked by a monitor.
module tb_fwd_scoreboard;
    localparam int RW  = 5;
    localparam int NP  = 2;
    localparam int D   = 4;
    localparam int SW  = $clog2(D+1);
    localparam int CWT = 4;

    logic               CLK, nRST;
    logic               issue_valid, issue_regwr, freeze, flush;
    logic [RW-1:0]      issue_rd;
    logic [SW-1:0]      issue_lat;
    logic [NP*RW-1:0]   rs_addr;
    logic [NP*SW-1:0]   fwd_sel;
    logic               stall_out;
    logic [SW-1:0]      pending_cnt;
    logic [CWT-1:0]     stall_cycles;

    fwd_scoreboard #(.RW(RW), .NPORTS(NP), .DEPTH(D), .CW(CWT)) dut (
        .CLK(CLK), .nRST(nRST), .issue_valid(issue_valid), .issue_regwr(issue_regwr),
        .issue_rd(issue_rd), .issue_lat(issue_lat), .rs_addr(rs_addr),
        .freeze(freeze), .flush(flush), .fwd_sel(fwd_sel), .stall_out(stall_out),
        .pending_cnt(pending_cnt), .stall_cycles(stall_cycles)
    );

    initial CLK = 0;
    always #5 CLK = ~CLK;

    typedef struct { bit v; int rd; int lat; } ent_t;
    typedef struct {
        logic [NP*SW-1:0] sel;
        logic             stall;
        logic [SW-1:0]    pend;
        logic [CWT-1:0]   cyc;
    } exp_t;

    ent_t sb[$];
    exp_t expq[$];
    int   m_cyc;
    bit   m_stall;
    int   n_vec, n_err;

    function automatic void model_reset();
        ent_t e;
        e = '{0, 0, 0};
        sb.delete();
        repeat (D) sb.push_back(e);
        m_cyc = 0;
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        bit   haz;
        int   rs;
        e.sel = '0;
        haz   = 0;
        for (int p = 0; p < NP; p++) begin
            rs = int'(rs_addr[p*RW +: RW]);
            if (rs != 0) begin
                for (int k = 0; k < D; k++) begin
                    if (sb[k].v && sb[k].rd == rs) begin
                        if (k >= sb[k].lat) e.sel[p*SW +: SW] = SW'(k + 1);
                        else haz = 1;
                        break;
                    end
                end
            end
        end
        e.stall = issue_valid && haz;
        e.pend  = '0;
        foreach (sb[k]) if (sb[k].v) e.pend = e.pend + SW'(1);
        e.cyc = CWT'(m_cyc);
        return e;
    endfunction

    function automatic void model_edge();
        ent_t n;
        int   l;
        if (freeze) return;
        n = '{0, 0, 0};
        if (flush) begin
            sb.push_front(n);
            sb[1].v = 0;
        end else if (m_stall) begin
            sb.push_front(n);
            if (m_cyc < (1 << CWT) - 1) m_cyc++;
        end else begin
            l = int'(issue_lat);
            n.v   = issue_valid && issue_regwr && issue_rd != 0;
            n.rd  = int'(issue_rd);
            n.lat = (l == 0) ? 1 : (l > D) ? D : l;
            sb.push_front(n);
        end
        void'(sb.pop_back());
    endfunction

    task automatic push_exp();
        exp_t e;
        e = model_outputs();
        m_stall = e.stall;
        expq.push_back(e);
    endtask

    task automatic step(input bit iv, input bit rw, input int rd, input int lat,
                        input int rs0, input int rs1, input bit fr, input bit fl);
        issue_valid = iv;
        issue_regwr = rw;
        issue_rd    = RW'(rd);
        issue_lat   = SW'(lat);
        rs_addr     = {RW'(rs1), RW'(rs0)};
        freeze      = fr;
        flush       = fl;
        push_exp();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic arst();
        #1;
        nRST = 0;
        model_reset();
        push_exp();
        @(posedge CLK);
        #1;
        nRST = 1;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            n_vec++;
            if (fwd_sel !== e.sel) begin
                n_err++;
                $display("FAIL fwd_sel t=%0t got %h want %h", $time, fwd_sel, e.sel);
            end
            if (stall_out !== e.stall) begin
                n_err++;
                $display("FAIL stall_out t=%0t got %b want %b", $time, stall_out, e.stall);
            end
            if (pending_cnt !== e.pend) begin
                n_err++;
                $display("FAIL pending_cnt t=%0t got %0d want %0d", $time, pending_cnt, e.pend);
            end
            if (stall_cycles !== e.cyc) begin
                n_err++;
                $display("FAIL stall_cycles t=%0t got %0d want %0d", $time, stall_cycles, e.cyc);
            end
        end
    end

    initial begin
        n_vec = 0; n_err = 0; m_stall = 0;
        nRST = 0; issue_valid = 0; issue_regwr = 0; issue_rd = '0; issue_lat = '0;
        rs_addr = '0; freeze = 0; flush = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        arst();
        // ALU chain
        step(1, 1, 3, 1, 0, 0, 0, 0);
        repeat (2) step(1, 1, 8, 1, 3, 0, 0, 0);
        step(1, 1, 9, 1, 0, 3, 0, 0);
        step(0, 0, 0, 0, 3, 3, 0, 0);
        // load-use
        step(1, 1, 5, 2, 0, 0, 0, 0);
        repeat (3) step(1, 1, 11, 1, 5, 0, 0, 0);
        // r0 and non-writing instructions
        step(1, 1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 7, 1, 0, 0, 0, 0);
        repeat (2) step(1, 0, 12, 1, 0, 7, 0, 0);
        // younger load shadows an older ALU writer of the same register
        step(1, 1, 4, 1, 0, 0, 0, 0);
        step(1, 1, 4, 2, 0, 0, 0, 0);
        repeat (3) step(1, 1, 13, 1, 4, 4, 0, 0);
        // freeze then flush with a reader waiting on a load
        step(1, 1, 6, 2, 0, 0, 0, 0);
        repeat (4) step(1, 1, 14, 1, 6, 0, 1, 1);
        step(1, 1, 14, 1, 6, 0, 0, 1);
        repeat (2) step(1, 1, 14, 1, 6, 0, 0, 0);
        // back-to-back never-forwardable writers saturate the stall counter
        repeat (30) step(1, 1, 6, D, 6, 6, 0, 0);
        arst();
        repeat (3) step(0, 0, 0, 0, 6, 0, 0, 0);
        // random traffic over a small register set to force collisions
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) arst();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                 $urandom_range(0, 7), $urandom_range(0, (1 << SW) - 1),
                 $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);
        end
        for (int i = 0; i < 5 && expq.size() > 0; i++) @(negedge CLK);
        if (expq.size() > 0) begin
            n_err++;
            $display("FAIL drain got %0d pending want 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
